key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive clock cycles a key level must hold before it is accepted (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter ACTIVE_LOW, default 1; when 1, a raw key at 0 means pressed, and when 0, a raw key at 1 means pressed.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key3  input  1  raw asynchronous pushbutton, reset function.
REQ-006 key2  input  1  raw asynchronous pushbutton, count function.
REQ-007 key1  input  1  raw asynchronous pushbutton, pause function.
REQ-008 key0  input  1  raw asynchronous pushbutton, stop function.
REQ-009 key_reset  output  1  registered single-cycle press pulse for key3.
REQ-010 key_contar  output  1  registered single-cycle press pulse for key2.
REQ-011 key_pausar  output  1  registered single-cycle press pulse for key1.
REQ-012 key_parar  output  1  registered single-cycle press pulse for key0.
REQ-013 pressed  output  4  registered debounced press level, active-high, ordered {key3,key2,key1,key0}.

Function
REQ-014 Each key SHALL pass through a two-flop synchronizer, normalised to active-high per ACTIVE_LOW, before any other logic.
REQ-015 Each key SHALL have a 16-bit counter that increments on every cycle where the synchronized level differs from pressed[i], and clears on any cycle where they match.
REQ-016 On the cycle the counter reaches DEBOUNCE_CYCLES with a mismatch still present, pressed[i] SHALL toggle and the counter SHALL clear.
REQ-017 A bounce shorter than DEBOUNCE_CYCLES SHALL leave pressed[i] unchanged and produce no pulse.
REQ-018 A 0->1 transition of pressed[i] SHALL set pending[i]; a 1->0 transition SHALL produce nothing.
REQ-019 Each cycle, at most one pulse output SHALL be high.
REQ-020 The pulse issued SHALL be the highest-priority pending key, with priority key0 > key1 > key2 > key3; that key's pending bit clears on issue.
REQ-021 Lower-priority pending bits SHALL be held and issued in later cycles, one per cycle, in priority order.
REQ-022 A new press on a key whose pending bit is already set SHALL merge into that bit and produce only one pulse.
REQ-023 Latency: a raw press stable from before edge k SHALL set pressed[i] after edge k+DEBOUNCE_CYCLES+1 and raise its pulse for exactly the cycle after edge k+DEBOUNCE_CYCLES+2, when no higher-priority key is pending.
REQ-024 A key held indefinitely SHALL produce exactly one pulse; a new pulse requires a debounced release followed by a debounced press.
REQ-025 When pending[i] sets on the same edge that a pulse for key i is issued, the new pending state SHALL win.

Reset
REQ-026 While reset is high at a clock edge, synchronizer flops SHALL load the released level and counters, pressed, pending and all pulse outputs SHALL load 0.
REQ-027 Reset SHALL override every other update on the same edge, including reset asserted mid-debounce and with pulses pending.
REQ-028 A key held through reset release SHALL be detected as a new press after the normal debounce latency.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-029 key2 driven 0 before edge 0 and held -> pressed=4'b0100 after edge 5; key_contar=1 only in the cycle after edge 6; no further pulses while held.
REQ-030 key1 low for 3 cycles, then high (glitch) -> pressed stays 0 and no pulse ever issued.
REQ-031 key0, key1 and key3 all driven low on the same cycle -> key_parar, key_pausar and key_reset pulse on three consecutive cycles, in that order, each one cycle wide.
REQ-032 key2 pressed, released for 5 cycles, then pressed again -> two key_contar pulses; a release held only 2 cycles -> one pulse.
REQ-033 reset asserted at edge 4 of a key0 press held throughout -> no pulse during reset; after reset deasserts, key_parar pulses once after the normal debounce latency.

Source files
------------

// File: rtl/key_debounce.sv
// Four-key pushbutton debouncer with a priority-ordered single-cycle press pulse.
// Each raw key is synchronised, normalised to active-high, and accepted only after
// holding a new level for DEBOUNCE_CYCLES consecutive cycles. Debounced presses
// queue as pending bits and are issued one per cycle, key0 first.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key3,
    input  logic       key2,
    input  logic       key1,
    input  logic       key0,
    output logic       key_reset,
    output logic       key_contar,
    output logic       key_pausar,
    output logic       key_parar,
    output logic [3:0] pressed
);

    // Counter value seen on the edge where the mismatch run reaches DEBOUNCE_CYCLES.
    localparam logic [15:0] LastCount = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  raw_keys;
    logic [3:0]  key_level;

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [15:0] count_q [4];
    logic [15:0] count_d [4];
    logic [3:0]  pressed_q;
    logic [3:0]  pressed_d;
    logic [3:0]  rise;
    logic [3:0]  pending_q;
    logic [3:0]  pending_d;
    logic [3:0]  grant;
    logic [3:0]  pulse_q;

    assign raw_keys  = {key3, key2, key1, key0};
    assign key_level = ACTIVE_LOW ? ~raw_keys : raw_keys;

    // Two-flop synchronizer; reset loads the released (not pressed) level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= key_level;
            sync2_q <= sync1_q;
        end
    end

    // Per-key mismatch-run counters; the debounced level flips when a run completes.
    always_comb begin
        pressed_d = pressed_q;
        rise      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            count_d[i] = 16'd0;
            if (sync2_q[i] != pressed_q[i]) begin
                if (count_q[i] == LastCount) begin
                    pressed_d[i] = ~pressed_q[i];
                    rise[i]      = ~pressed_q[i];
                end else begin
                    count_d[i] = count_q[i] + 16'd1;
                end
            end
        end
    end

    // Grant the lowest-index pending key; a fresh rise on the granted key re-arms it.
    always_comb begin
        grant     = pending_q & (~pending_q + 4'd1);
        pending_d = (pending_q & ~grant) | rise;
    end

    // Debounce state, pending queue and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= 16'd0;
            end
            pressed_q <= 4'b0000;
            pending_q <= 4'b0000;
            pulse_q   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= count_d[i];
            end
            pressed_q <= pressed_d;
            pending_q <= pending_d;
            pulse_q   <= grant;
        end
    end

    assign pressed    = pressed_q;
    assign key_parar  = pulse_q[0];
    assign key_pausar = pulse_q[1];
    assign key_contar = pulse_q[2];
    assign key_reset  = pulse_q[3];

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios with fixed expected edges plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_key_debounce;

    localparam int unsigned N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       key3, key2, key1, key0;
    logic       key_reset, key_contar, key_pausar, key_parar;
    logic [3:0] pressed;
    logic [3:0] pulses;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [3:0] m_s1, m_s2, m_pressed, m_pend, m_pulse;
    int         m_run [4];

    int edge_n;
    int pulse_cnt [4];
    int first_pulse [4];
    int first_press [4];

    always #5 clock = ~clock;

    key_debounce #(
        .DEBOUNCE_CYCLES(N),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key3      (key3),
        .key2      (key2),
        .key1      (key1),
        .key0      (key0),
        .key_reset (key_reset),
        .key_contar(key_contar),
        .key_pausar(key_pausar),
        .key_parar (key_parar),
        .pressed   (pressed)
    );

    assign pulses = {key_reset, key_contar, key_pausar, key_parar};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural model of one clock edge, using the inputs present at that edge.
    task automatic model_step();
        logic [3:0] raw;
        logic [3:0] nxt;
        logic [3:0] rise;
        logic [3:0] grant;
        raw = {key3, key2, key1, key0};
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_pressed = 0; m_pend = 0; m_pulse = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            nxt  = m_pressed;
            rise = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_pressed[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= N) begin
                        nxt[i]   = ~m_pressed[i];
                        rise[i]  = nxt[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            grant = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && grant == 0) grant[i] = 1'b1;
            end
            m_pulse   = grant;
            m_pend    = (m_pend & ~grant) | rise;
            m_pressed = nxt;
            m_s2      = m_s1;
            m_s1      = ~raw;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_eq("pressed", 16'(pressed), 16'(m_pressed));
        check_eq("pulses", 16'(pulses), 16'(m_pulse));
        check_eq("onehot0", 16'($onehot0(pulses)), 16'd1);
        for (int i = 0; i < 4; i++) begin
            if (pulses[i] === 1'b1) begin
                pulse_cnt[i]++;
                if (first_pulse[i] < 0) first_pulse[i] = edge_n;
            end
            if (pressed[i] === 1'b1 && first_press[i] < 0) first_press[i] = edge_n;
        end
        edge_n++;
    endtask

    task automatic start_scenario();
        reset = 1'b1;
        {key3, key2, key1, key0} = 4'b1111;
        tick();
        tick();
        check_eq("reset_state", 16'({pressed, pulses}), 16'd0);
        reset  = 1'b0;
        edge_n = 0;
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i]   = 0;
            first_pulse[i] = -1;
            first_press[i] = -1;
        end
    endtask

    initial begin
        reset = 1'b1;
        {key3, key2, key1, key0} = 4'b1111;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        {m_s1, m_s2, m_pressed, m_pend, m_pulse} = '0;

        // Held press: pressed after edge 5, one pulse after edge 6.
        start_scenario();
        key2 = 1'b0;
        for (int e = 0; e < 30; e++) tick();
        check_eq("hold_press_edge", 16'(first_press[2]), 16'd5);
        check_eq("hold_pulse_edge", 16'(first_pulse[2]), 16'd6);
        check_eq("hold_pulse_cnt", 16'(pulse_cnt[2]), 16'd1);

        // Glitch shorter than the debounce window.
        start_scenario();
        for (int e = 0; e < 20; e++) begin
            key1 = (e >= 3);
            tick();
        end
        check_eq("glitch_press", 16'(first_press[1]), 16'hFFFF);
        check_eq("glitch_pulse_cnt", 16'(pulse_cnt[1]), 16'd0);

        // Simultaneous presses issue in priority order.
        start_scenario();
        {key3, key1, key0} = 3'b000;
        for (int e = 0; e < 20; e++) tick();
        check_eq("prio_k0_edge", 16'(first_pulse[0]), 16'd6);
        check_eq("prio_k1_edge", 16'(first_pulse[1]), 16'd7);
        check_eq("prio_k3_edge", 16'(first_pulse[3]), 16'd8);
        check_eq("prio_cnt", 16'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[3]), 16'd3);

        // Release of 5 cycles gives a second pulse.
        start_scenario();
        for (int e = 0; e < 36; e++) begin
            key2 = (e >= 10 && e < 15);
            tick();
        end
        check_eq("rel5_pulse_cnt", 16'(pulse_cnt[2]), 16'd2);

        // Release of 2 cycles is a bounce.
        start_scenario();
        for (int e = 0; e < 36; e++) begin
            key2 = (e >= 10 && e < 12);
            tick();
        end
        check_eq("rel2_pulse_cnt", 16'(pulse_cnt[2]), 16'd1);

        // Reset mid-debounce restarts the press detection.
        start_scenario();
        key0 = 1'b0;
        for (int e = 0; e < 26; e++) begin
            reset = (e == 4);
            tick();
        end
        reset = 1'b0;
        check_eq("rst_press_edge", 16'(first_press[0]), 16'd10);
        check_eq("rst_pulse_edge", 16'(first_pulse[0]), 16'd11);
        check_eq("rst_pulse_cnt", 16'(pulse_cnt[0]), 16'd1);

        // Randomized key activity with occasional resets.
        start_scenario();
        for (int e = 0; e < 2000; e++) begin
            if ($urandom_range(0, 5) == 0) key0 = ~key0;
            if ($urandom_range(0, 5) == 0) key1 = ~key1;
            if ($urandom_range(0, 5) == 0) key2 = ~key2;
            if ($urandom_range(0, 5) == 0) key3 = ~key3;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
